ecc_point_seq: RTL and testbench
================================

Name: ecc_point_seq

Overview:
- Initiator/controller for the GF(p) arithmetic unit: drives operand, operation-select and start signals, waits for the unit's done, and captures its result.
- Sequences a fixed microprogram that computes affine elliptic-curve point addition (P+Q) or doubling (2P) over GF(p), one field operation at a time.
- Sits between the top-level ECC scalar-multiply loop and the arithmetic unit.

Parameters:
- SIZE, 32, field element width (matches the arithmetic unit).
- TIMEOUT_CYCLES, 512, watchdog limit per field operation (used only with the optional feature).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- dbl  in  1  1 = compute 2P, 0 = compute P+Q
- x1, y1, x2, y2  in  SIZE  operand points (x2/y2 ignored when dbl=1)
- a  in  SIZE  curve coefficient a
- prime  in  SIZE  field modulus p
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- inf  out  1  result is the point at infinity; valid with done
- x3, y3  out  SIZE  result point; held until the next accepted start
- err  out  1  watchdog abort (tied 0 without the optional feature)
- gf_in_0, gf_in_1  out  SIZE  unit operands
- gf_prime  out  SIZE  driven from the latched prime
- gf_op_sel  out  2  0 add, 1 sub, 2 mult, 3 div (in_0/in_1)
- gf_start  out  1  one-cycle select pulse to the unit
- gf_done  in  1  unit completion
- gf_result  in  SIZE  unit result, valid while gf_done=1

Behaviour:
- Reset: all outputs 0; all internal registers 0; FSM enters IDLE. Reset mid-operation abandons the sequence immediately; no done pulse.
- FSM states: IDLE, CHECK, ISSUE, WAIT, NEXT, FIN.
- IDLE: on start, latch x1, y1, x2, y2, a, prime and dbl; go to CHECK. A start received in any other state is ignored.
- CHECK, special cases:
  - dbl=1 and y1=0: result is infinity.
  - dbl=0, x1=x2 and y1≠y2: result is infinity.
  - dbl=0, x1=x2 and y1=y2: switch to the doubling program.
  - Infinity path: x3=y3=0, inf=1, go to FIN; no unit operations issued.
- Otherwise set pc=0 and go to ISSUE.
- ISSUE: drive gf_in_0, gf_in_1 and gf_op_sel from ROM[pc]; assert gf_start for exactly this cycle; go to WAIT.
- WAIT: operands and op_sel held stable; the unit's multiplier reads in_0 serially across its whole operation. When gf_done=1, write gf_result to the ROM destination register, then go to NEXT.
- NEXT: if pc is the last entry go to FIN, else pc+1 and go to ISSUE.
- FIN: done=1 for one cycle, busy drops in the same cycle, return to IDLE.
- Add program, 9 ops (T0..T3 temporaries, L is lambda):
  - T0=y2-y1, T1=x2-x1, L=T0/T1, T2=L*L, T2=T2-x1, X3=T2-x2, T3=x1-X3, T3=L*T3, Y3=T3-y1.
- Double program, 12 ops:
  - T0=x1*x1, T1=T0+T0, T0=T1+T0, T0=T0+a, T1=y1+y1, L=T0/T1, T2=L*L, T2=T2-x1, X3=T2-x1, T3=x1-X3, T3=L*T3, Y3=T3-y1.
- Arithmetic: no arithmetic is performed locally; the unit performs all modular arithmetic. Only equality compares occur, in CHECK.
- Infinity latency: done asserts 2 cycles after start is sampled.
- gf_done asserted outside WAIT is ignored.

Optional Feature:
- Macro: ECC_POINT_SEQ_TIMEOUT_EN.
- Enabled: a counter runs in WAIT. If gf_done is absent for TIMEOUT_CYCLES, go to FIN with err=1, x3=y3=0, inf=0.
- err clears on the next accepted start.
- Disabled: no counter; WAIT waits indefinitely; err is constant 0.

Decomposition:
- Shared package (gf_pkg):
  - GF op-select constants GF_ADD/GF_SUB/GF_MULT/GF_DIV.
  - Operand-source enum: X1, Y1, X2, Y2, A, T0, T1, T2, T3, L, X3.
  - Microinstruction struct: op, srcA, srcB, dst.
  - FSM state enum.
- Sub-module ecc_point_rom: combinational, inputs pc and dbl, output a microinstruction plus a last flag.

Test Plan:
- p=23, a=1, dbl=0, P=(3,10), Q=(9,7) -> done, x3=17, y3=20, inf=0; exactly 9 gf_start pulses.
- p=23, a=1, dbl=1, P=(3,10) -> x3=7, y3=12; 12 gf_start pulses; gf_in_0 stable during every WAIT.
- dbl=0, P=Q=(3,10) -> falls through to doubling program, x3=7, y3=12.
- dbl=0, P=(3,10), Q=(3,13) -> inf=1, x3=y3=0, done 2 cycles after start, zero gf_start pulses; repeat with dbl=1, y1=0 -> same.
- Assert i_rst low during a div WAIT -> all outputs 0 next edge; no done. A new start afterwards yields the correct (17,20).
- With ECC_POINT_SEQ_TIMEOUT_EN, stub never asserts gf_done -> err=1 and done after 512 WAIT cycles; next start clears err.

Source files
------------

// File: rtl/gf_pkg.sv
// gf_pkg
// Shared definitions for the elliptic-curve point sequencer and its
// microprogram ROM:
//   GF_ADD/GF_SUB/GF_MULT/GF_DIV  op-select codes for the GF(p) unit
//   src_e                         operand/destination register selector
//   uinstr_t                      one microinstruction (op, srcA, srcB, dst)
//   state_e                       sequencer FSM states
//   mk_uinstr()                   helper to build a microinstruction
package gf_pkg;

   localparam logic [1:0] GF_ADD  = 2'd0;
   localparam logic [1:0] GF_SUB  = 2'd1;
   localparam logic [1:0] GF_MULT = 2'd2;
   localparam logic [1:0] GF_DIV  = 2'd3;

   // Program counter width; the longest program has 12 entries.
   localparam int PC_W = 4;

   // Register file slots. Y3 exists only as a destination, so that the
   // last instruction of both programs can write the result directly.
   typedef enum logic [3:0] {
      SRC_X1, SRC_Y1, SRC_X2, SRC_Y2, SRC_A,
      SRC_T0, SRC_T1, SRC_T2, SRC_T3, SRC_L,
      SRC_X3, SRC_Y3
   } src_e;

   localparam int NUM_REGS = 12;

   typedef struct packed {
      logic [1:0] op;
      src_e       src_a;
      src_e       src_b;
      src_e       dst;
   } uinstr_t;

   typedef enum logic [2:0] {
      ST_IDLE, ST_CHECK, ST_ISSUE, ST_WAIT, ST_NEXT, ST_FIN
   } state_e;

   function automatic uinstr_t mk_uinstr(input logic [1:0] op, input src_e src_a,
                                         input src_e src_b, input src_e dst);
      uinstr_t u;
      u.op    = op;
      u.src_a = src_a;
      u.src_b = src_b;
      u.dst   = dst;
      return u;
   endfunction

endpackage

// File: rtl/ecc_point_rom.sv
// ecc_point_rom
// Combinational microprogram store for affine point addition (9 ops) and
// point doubling (12 ops).
// Ports:
//   pc     in   program counter
//   dbl    in   1 selects the doubling program, 0 the addition program
//   instr  out  microinstruction at pc
//   last   out  pc is the final entry of the selected program
module ecc_point_rom
   import gf_pkg::*;
(
   input  logic [PC_W-1:0] pc,
   input  logic            dbl,
   output uinstr_t         instr,
   output logic            last
);

   // Out-of-range pc values report last so a corrupted pc cannot run away.
   always_comb begin
      instr = mk_uinstr(GF_ADD, SRC_X1, SRC_X1, SRC_T0);
      last  = 1'b0;
      if (dbl) begin
         case (pc)
            4'd0:  instr = mk_uinstr(GF_MULT, SRC_X1, SRC_X1, SRC_T0);
            4'd1:  instr = mk_uinstr(GF_ADD,  SRC_T0, SRC_T0, SRC_T1);
            4'd2:  instr = mk_uinstr(GF_ADD,  SRC_T1, SRC_T0, SRC_T0);
            4'd3:  instr = mk_uinstr(GF_ADD,  SRC_T0, SRC_A,  SRC_T0);
            4'd4:  instr = mk_uinstr(GF_ADD,  SRC_Y1, SRC_Y1, SRC_T1);
            4'd5:  instr = mk_uinstr(GF_DIV,  SRC_T0, SRC_T1, SRC_L);
            4'd6:  instr = mk_uinstr(GF_MULT, SRC_L,  SRC_L,  SRC_T2);
            4'd7:  instr = mk_uinstr(GF_SUB,  SRC_T2, SRC_X1, SRC_T2);
            4'd8:  instr = mk_uinstr(GF_SUB,  SRC_T2, SRC_X1, SRC_X3);
            4'd9:  instr = mk_uinstr(GF_SUB,  SRC_X1, SRC_X3, SRC_T3);
            4'd10: instr = mk_uinstr(GF_MULT, SRC_L,  SRC_T3, SRC_T3);
            4'd11: begin
               instr = mk_uinstr(GF_SUB, SRC_T3, SRC_Y1, SRC_Y3);
               last  = 1'b1;
            end
            default: last = 1'b1;
         endcase
      end else begin
         case (pc)
            4'd0: instr = mk_uinstr(GF_SUB,  SRC_Y2, SRC_Y1, SRC_T0);
            4'd1: instr = mk_uinstr(GF_SUB,  SRC_X2, SRC_X1, SRC_T1);
            4'd2: instr = mk_uinstr(GF_DIV,  SRC_T0, SRC_T1, SRC_L);
            4'd3: instr = mk_uinstr(GF_MULT, SRC_L,  SRC_L,  SRC_T2);
            4'd4: instr = mk_uinstr(GF_SUB,  SRC_T2, SRC_X1, SRC_T2);
            4'd5: instr = mk_uinstr(GF_SUB,  SRC_T2, SRC_X2, SRC_X3);
            4'd6: instr = mk_uinstr(GF_SUB,  SRC_X1, SRC_X3, SRC_T3);
            4'd7: instr = mk_uinstr(GF_MULT, SRC_L,  SRC_T3, SRC_T3);
            4'd8: begin
               instr = mk_uinstr(GF_SUB, SRC_T3, SRC_Y1, SRC_Y3);
               last  = 1'b1;
            end
            default: last = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/ecc_point_seq.sv
// ecc_point_seq
// Controller that computes affine P+Q or 2P over GF(p) by issuing one field
// operation at a time to an external GF(p) arithmetic unit.
// Optional feature macro: ECC_POINT_SEQ_TIMEOUT_EN (per-operation watchdog).
// Ports:
//   i_clk, i_rst              clock; asynchronous active-low reset
//   start, dbl                request (sampled in IDLE) and add/double select
//   x1, y1, x2, y2, a, prime  operand points, curve coefficient, modulus
//   busy, done, inf, err      status; done is a one-cycle pulse
//   x3, y3                    result point, held until the next accepted start
//   gf_in_0, gf_in_1          unit operands
//   gf_prime, gf_op_sel       unit modulus and operation select
//   gf_start                  one-cycle operation launch
//   gf_done, gf_result        unit completion and result
module ecc_point_seq
   import gf_pkg::*;
#(
   parameter int SIZE           = 32,
   parameter int TIMEOUT_CYCLES = 512
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            start,
   input  logic            dbl,
   input  logic [SIZE-1:0] x1,
   input  logic [SIZE-1:0] y1,
   input  logic [SIZE-1:0] x2,
   input  logic [SIZE-1:0] y2,
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] prime,
   output logic            busy,
   output logic            done,
   output logic            inf,
   output logic [SIZE-1:0] x3,
   output logic [SIZE-1:0] y3,
   output logic            err,
   output logic [SIZE-1:0] gf_in_0,
   output logic [SIZE-1:0] gf_in_1,
   output logic [SIZE-1:0] gf_prime,
   output logic [1:0]      gf_op_sel,
   output logic            gf_start,
   input  logic            gf_done,
   input  logic [SIZE-1:0] gf_result
);

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            dbl_q, dbl_d;
   logic            inf_q, inf_d;
   logic [SIZE-1:0] prime_q, prime_d;
   logic [SIZE-1:0] regs_q [NUM_REGS];
   logic [SIZE-1:0] regs_d [NUM_REGS];

   uinstr_t         rom_instr;
   logic            rom_last;
   logic            op_active;

`ifdef ECC_POINT_SEQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
`endif

   ecc_point_rom u_rom (
      .pc    (pc_q),
      .dbl   (dbl_q),
      .instr (rom_instr),
      .last  (rom_last)
   );

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         dbl_q   <= 1'b0;
         inf_q   <= 1'b0;
         prime_q <= '0;
         regs_q  <= '{default: '0};
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         dbl_q   <= dbl_d;
         inf_q   <= inf_d;
         prime_q <= prime_d;
         regs_q  <= regs_d;
      end
   end

`ifdef ECC_POINT_SEQ_TIMEOUT_EN
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
`endif

   // Next-state logic. A P+Q request with P==Q is rerouted to the doubling
   // program in CHECK because the addition formula would divide by zero.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      dbl_d   = dbl_q;
      inf_d   = inf_q;
      prime_d = prime_q;
      regs_d  = regs_q;
`ifdef ECC_POINT_SEQ_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               regs_d[SRC_X1] = x1;
               regs_d[SRC_Y1] = y1;
               regs_d[SRC_X2] = x2;
               regs_d[SRC_Y2] = y2;
               regs_d[SRC_A]  = a;
               regs_d[SRC_X3] = '0;
               regs_d[SRC_Y3] = '0;
               prime_d        = prime;
               dbl_d          = dbl;
               inf_d          = 1'b0;
`ifdef ECC_POINT_SEQ_TIMEOUT_EN
               err_d          = 1'b0;
`endif
               state_d        = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if ((dbl_q && (regs_q[SRC_Y1] == '0)) ||
                (!dbl_q && (regs_q[SRC_X1] == regs_q[SRC_X2]) &&
                 (regs_q[SRC_Y1] != regs_q[SRC_Y2]))) begin
               inf_d   = 1'b1;
               state_d = ST_FIN;
            end else begin
               if (!dbl_q && (regs_q[SRC_X1] == regs_q[SRC_X2])) begin
                  dbl_d = 1'b1;
               end
               pc_d    = '0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
`ifdef ECC_POINT_SEQ_TIMEOUT_EN
            cnt_d   = '0;
`endif
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (gf_done) begin
               regs_d[rom_instr.dst] = gf_result;
               state_d               = ST_NEXT;
            end
`ifdef ECC_POINT_SEQ_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               err_d          = 1'b1;
               inf_d          = 1'b0;
               regs_d[SRC_X3] = '0;
               regs_d[SRC_Y3] = '0;
               state_d        = ST_FIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         ST_NEXT: begin
            if (rom_last) begin
               state_d = ST_FIN;
            end else begin
               pc_d    = pc_q + 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Unit-facing signals are only meaningful while an operation is in
   // flight; elsewhere they are forced to zero so an idle unit sees no
   // stale operands or op codes.
   assign op_active = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
   assign gf_start  = (state_q == ST_ISSUE);
   assign gf_op_sel = op_active ? rom_instr.op : 2'd0;
   assign gf_in_0   = op_active ? regs_q[rom_instr.src_a] : '0;
   assign gf_in_1   = op_active ? regs_q[rom_instr.src_b] : '0;
   assign gf_prime  = prime_q;

   assign busy = (state_q == ST_CHECK) || (state_q == ST_ISSUE) ||
                 (state_q == ST_WAIT)  || (state_q == ST_NEXT);
   assign done = (state_q == ST_FIN);
   assign inf  = inf_q;
   assign x3   = regs_q[SRC_X3];
   assign y3   = regs_q[SRC_Y3];

`ifdef ECC_POINT_SEQ_TIMEOUT_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_point_seq.sv
// tb_ecc_point_seq
// Testbench for ecc_point_seq with a behavioural GF(p) unit responder.
// Define ECC_POINT_SEQ_TIMEOUT_EN to also exercise the watchdog.
module tb_ecc_point_seq;

   localparam int SIZE           = 32;
   localparam int TIMEOUT_CYCLES = 512;

   logic            i_clk = 1'b0;
   logic            i_rst = 1'b0;
   logic            start = 1'b0;
   logic            dbl   = 1'b0;
   logic [SIZE-1:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0, a = '0, prime = '0;
   logic            busy, done, inf, err, gf_start;
   logic [SIZE-1:0] x3, y3, gf_in_0, gf_in_1, gf_prime;
   logic [1:0]      gf_op_sel;
   logic            gf_done;
   logic [SIZE-1:0] gf_result;

   int checks     = 0;
   int failures   = 0;
   int start_count = 0;
   int done_count  = 0;
   bit stable_err  = 1'b0;
   bit slow_div    = 1'b0;
   bit hang        = 1'b0;
   bit inject      = 1'b0;

   typedef struct {
      logic [SIZE-1:0] x3;
      logic [SIZE-1:0] y3;
      logic            inf;
      logic            err;
   } exp_t;

   exp_t sb[$];

   ecc_point_seq #(.SIZE(SIZE), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .start     (start),
      .dbl       (dbl),
      .x1        (x1),
      .y1        (y1),
      .x2        (x2),
      .y2        (y2),
      .a         (a),
      .prime     (prime),
      .busy      (busy),
      .done      (done),
      .inf       (inf),
      .x3        (x3),
      .y3        (y3),
      .err       (err),
      .gf_in_0   (gf_in_0),
      .gf_in_1   (gf_in_1),
      .gf_prime  (gf_prime),
      .gf_op_sel (gf_op_sel),
      .gf_start  (gf_start),
      .gf_done   (gf_done),
      .gf_result (gf_result)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [63:0] mod_pow(input logic [63:0] b_in, input logic [63:0] e_in,
                                           input logic [63:0] m);
      logic [63:0] r, b, e;
      r = 64'd1;
      b = b_in % m;
      e = e_in;
      while (e != 0) begin
         if (e[0]) r = (r * b) % m;
         b = (b * b) % m;
         e = e >> 1;
      end
      return r;
   endfunction

   // Reference modular arithmetic of the GF(p) unit.
   function automatic logic [SIZE-1:0] gf_model(input logic [1:0] op, input logic [SIZE-1:0] u,
                                                input logic [SIZE-1:0] v, input logic [SIZE-1:0] p);
      logic [63:0] uu, vv, pp, r;
      pp = {32'd0, p};
      uu = {32'd0, u} % pp;
      vv = {32'd0, v} % pp;
      case (op)
         2'd0:    r = (uu + vv) % pp;
         2'd1:    r = (uu + pp - vv) % pp;
         2'd2:    r = (uu * vv) % pp;
         default: r = (uu * mod_pow(vv, pp - 64'd2, pp)) % pp;
      endcase
      return r[SIZE-1:0];
   endfunction

   // GF(p) unit responder: latches each request, answers after a variable
   // latency, and flags any operand/op change while the request is pending.
   initial begin : gf_stub
      logic [SIZE-1:0] l0, l1, res;
      logic [1:0]      lop;
      int              delay;
      bit              pending;
      pending   = 1'b0;
      delay     = 0;
      gf_done   = 1'b0;
      gf_result = '0;
      forever begin
         @(posedge i_clk);
         #1;
         gf_done   = 1'b0;
         gf_result = '0;
         if (!i_rst) begin
            pending = 1'b0;
         end else if (inject) begin
            gf_done   = 1'b1;
            gf_result = 32'h1234;
            inject    = 1'b0;
         end else begin
            if (gf_start) start_count++;
            if (pending) begin
               if ({gf_in_0, gf_in_1, gf_op_sel} !== {l0, l1, lop}) stable_err = 1'b1;
               if (delay == 0) begin
                  gf_done   = 1'b1;
                  gf_result = res;
                  pending   = 1'b0;
               end else begin
                  delay--;
               end
            end else if (gf_start && !hang) begin
               l0      = gf_in_0;
               l1      = gf_in_1;
               lop     = gf_op_sel;
               res     = gf_model(lop, l0, l1, gf_prime);
               delay   = (slow_div && lop == 2'd3) ? 20 : (start_count % 3);
               pending = 1'b1;
            end
         end
      end
   end

   initial begin : done_mon
      forever begin
         @(posedge i_clk);
         #1;
         if (done === 1'b1) done_count++;
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL global_timeout simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

   task automatic send_start(input logic d, input logic [SIZE-1:0] px1, input logic [SIZE-1:0] py1,
                             input logic [SIZE-1:0] px2, input logic [SIZE-1:0] py2,
                             input logic [SIZE-1:0] ex3, input logic [SIZE-1:0] ey3,
                             input logic einf, input logic eerr);
      exp_t e;
      @(negedge i_clk);
      if (done === 1'b1) @(negedge i_clk);
      dbl   = d;
      x1    = px1;
      y1    = py1;
      x2    = px2;
      y2    = py2;
      start = 1'b1;
      e.x3 = ex3; e.y3 = ey3; e.inf = einf; e.err = eerr;
      sb.push_back(e);
      @(posedge i_clk);
      #1;
      start = 1'b0;
      x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom;
   endtask

   // Counts edges from the one that sampled start (edge 1) until done is seen.
   task automatic wait_done(input int limit, output int cycles, output bit timed_out);
      cycles    = 1;
      timed_out = 1'b1;
      for (int i = 0; i < limit; i++) begin
         @(posedge i_clk);
         #1;
         cycles++;
         if (done === 1'b1) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({busy, done, inf, err, x3, y3, gf_in_0, gf_in_1, gf_prime, gf_op_sel, gf_start} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got busy=%0b done=%0b inf=%0b x3=%0d y3=%0d prime=%0d op=%0d start=%0b exp all 0",
                  busy, done, inf, x3, y3, gf_prime, gf_op_sel, gf_start);
      end
   endtask

   task automatic test_point_ops();
      logic            vd  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [SIZE-1:0] vx1 [5] = '{32'd3, 32'd3, 32'd3, 32'd9, 32'd3};
      logic [SIZE-1:0] vy1 [5] = '{32'd10, 32'd10, 32'd10, 32'd7, 32'd10};
      logic [SIZE-1:0] vx2 [5] = '{32'd9, 32'd7, 32'd0, 32'd0, 32'd3};
      logic [SIZE-1:0] vy2 [5] = '{32'd7, 32'd12, 32'd0, 32'd0, 32'd10};
      logic [SIZE-1:0] ex  [5] = '{32'd17, 32'd19, 32'd7, 32'd6, 32'd7};
      logic [SIZE-1:0] ey  [5] = '{32'd20, 32'd5, 32'd12, 32'd19, 32'd12};
      int              eops[5] = '{9, 9, 12, 12, 12};
      exp_t e;
      int   cyc, s0;
      bit   to;
      prime = 32'd23;
      a     = 32'd1;
      for (int i = 0; i < 5; i++) begin
         s0         = start_count;
         stable_err = 1'b0;
         send_start(vd[i], vx1[i], vy1[i], vx2[i], vy2[i], ex[i], ey[i], 1'b0, 1'b0);
         checks++;
         if (busy !== 1'b1) begin
            failures++;
            $display("FAIL op%0d_busy got=%0b exp=1", i, busy);
         end
         wait_done(400, cyc, to);
         e = sb.pop_front();
         checks++;
         if (to || {x3, y3, inf, err} !== {e.x3, e.y3, e.inf, e.err}) begin
            failures++;
            $display("FAIL op%0d_result timeout=%0b got x3=%0d y3=%0d inf=%0b err=%0b exp x3=%0d y3=%0d inf=%0b err=%0b",
                     i, to, x3, y3, inf, err, e.x3, e.y3, e.inf, e.err);
         end
         checks++;
         if (start_count - s0 != eops[i]) begin
            failures++;
            $display("FAIL op%0d_gf_starts got=%0d exp=%0d", i, start_count - s0, eops[i]);
         end
         checks++;
         if (stable_err) begin
            failures++;
            $display("FAIL op%0d_operand_stability got=changed exp=stable", i);
         end
         @(posedge i_clk);
         #1;
         checks++;
         if ({done, busy, x3, y3} !== {1'b0, 1'b0, e.x3, e.y3}) begin
            failures++;
            $display("FAIL op%0d_after_done got done=%0b busy=%0b x3=%0d y3=%0d exp done=0 busy=0 x3=%0d y3=%0d",
                     i, done, busy, x3, y3, e.x3, e.y3);
         end
      end
   endtask

   task automatic test_infinity();
      logic            vd  [2] = '{1'b0, 1'b1};
      logic [SIZE-1:0] vy1 [2] = '{32'd10, 32'd0};
      exp_t e;
      int   cyc, s0;
      bit   to;
      for (int i = 0; i < 2; i++) begin
         s0 = start_count;
         send_start(vd[i], 32'd3, vy1[i], 32'd3, 32'd13, 32'd0, 32'd0, 1'b1, 1'b0);
         wait_done(20, cyc, to);
         e = sb.pop_front();
         checks++;
         if (to || {x3, y3, inf, err} !== {e.x3, e.y3, e.inf, e.err}) begin
            failures++;
            $display("FAIL inf%0d_result timeout=%0b got x3=%0d y3=%0d inf=%0b exp x3=0 y3=0 inf=1", i, to, x3, y3, inf);
         end
         checks++;
         if (cyc != 2) begin
            failures++;
            $display("FAIL inf%0d_latency got=%0d exp=2", i, cyc);
         end
         checks++;
         if (start_count != s0) begin
            failures++;
            $display("FAIL inf%0d_gf_starts got=%0d exp=0", i, start_count - s0);
         end
      end
   endtask

   task automatic test_ignore();
      exp_t e;
      int   cyc, s0;
      bit   to;
      s0 = start_count;
      send_start(1'b0, 32'd3, 32'd10, 32'd9, 32'd7, 32'd17, 32'd20, 1'b0, 1'b0);
      repeat (4) @(negedge i_clk);
      dbl = 1'b1; x1 = 32'd9; y1 = 32'd7; start = 1'b1;
      @(negedge i_clk);
      start = 1'b0;
      wait_done(400, cyc, to);
      e = sb.pop_front();
      checks++;
      if (to || {x3, y3, inf} !== {e.x3, e.y3, e.inf} || start_count - s0 != 9) begin
         failures++;
         $display("FAIL busy_start_ignored timeout=%0b got x3=%0d y3=%0d starts=%0d exp x3=%0d y3=%0d starts=9",
                  to, x3, y3, start_count - s0, e.x3, e.y3);
      end
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      inject = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      checks++;
      if ({busy, done, x3, y3} !== {1'b0, 1'b0, e.x3, e.y3}) begin
         failures++;
         $display("FAIL idle_gf_done_ignored got busy=%0b done=%0b x3=%0d y3=%0d exp busy=0 done=0 x3=%0d y3=%0d",
                  busy, done, x3, y3, e.x3, e.y3);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   cyc;
      bit   to;
      send_start(1'b1, 32'd9, 32'd7, 32'd0, 32'd0, 32'd6, 32'd19, 1'b0, 1'b0);
      wait_done(400, cyc, to);
      send_start(1'b0, 32'd3, 32'd10, 32'd7, 32'd12, 32'd19, 32'd5, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (busy !== 1'b1 || to) begin
         failures++;
         $display("FAIL b2b_second_accepted got busy=%0b timeout=%0b exp busy=1 timeout=0", busy, to);
      end
      wait_done(400, cyc, to);
      e = sb.pop_front();
      checks++;
      if (to || {x3, y3, inf} !== {e.x3, e.y3, e.inf}) begin
         failures++;
         $display("FAIL b2b_result timeout=%0b got x3=%0d y3=%0d exp x3=%0d y3=%0d", to, x3, y3, e.x3, e.y3);
      end
   endtask

   task automatic test_reset_midop();
      exp_t e;
      int   cyc, dc;
      bit   to, found;
      slow_div = 1'b1;
      found    = 1'b0;
      send_start(1'b0, 32'd3, 32'd10, 32'd9, 32'd7, 32'd17, 32'd20, 1'b0, 1'b0);
      for (int i = 0; i < 100; i++) begin
         @(posedge i_clk);
         #1;
         if (busy === 1'b1 && gf_op_sel === 2'd3 && gf_start === 1'b0) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL midop_div_wait got=not_reached exp=reached");
      end
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      dc    = done_count;
      i_rst = 1'b0;
      #1;
      checks++;
      if ({busy, done, inf, err, x3, y3, gf_in_0, gf_in_1, gf_prime, gf_op_sel, gf_start} !== '0) begin
         failures++;
         $display("FAIL midop_reset_outputs got busy=%0b done=%0b in0=%0d in1=%0d prime=%0d op=%0d exp all 0",
                  busy, done, gf_in_0, gf_in_1, gf_prime, gf_op_sel);
      end
      sb.delete();
      slow_div = 1'b0;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b1;
      repeat (6) @(posedge i_clk);
      #1;
      checks++;
      if (done_count != dc || busy !== 1'b0) begin
         failures++;
         $display("FAIL midop_no_done got dones=%0d busy=%0b exp dones=0 busy=0", done_count - dc, busy);
      end
      send_start(1'b0, 32'd3, 32'd10, 32'd9, 32'd7, 32'd17, 32'd20, 1'b0, 1'b0);
      wait_done(400, cyc, to);
      e = sb.pop_front();
      checks++;
      if (to || {x3, y3, inf} !== {e.x3, e.y3, e.inf}) begin
         failures++;
         $display("FAIL midop_rerun timeout=%0b got x3=%0d y3=%0d exp x3=%0d y3=%0d", to, x3, y3, e.x3, e.y3);
      end
   endtask

`ifdef ECC_POINT_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      exp_t e;
      int   cyc;
      bit   to;
      hang = 1'b1;
      send_start(1'b0, 32'd3, 32'd10, 32'd9, 32'd7, 32'd0, 32'd0, 1'b0, 1'b1);
      wait_done(TIMEOUT_CYCLES + 100, cyc, to);
      e = sb.pop_front();
      checks++;
      if (to || {x3, y3, inf, err} !== {e.x3, e.y3, e.inf, e.err}) begin
         failures++;
         $display("FAIL timeout_result timeout=%0b got x3=%0d y3=%0d inf=%0b err=%0b exp x3=0 y3=0 inf=0 err=1",
                  to, x3, y3, inf, err);
      end
      checks++;
      if (cyc != TIMEOUT_CYCLES + 3) begin
         failures++;
         $display("FAIL timeout_latency got=%0d exp=%0d", cyc, TIMEOUT_CYCLES + 3);
      end
      hang = 1'b0;
      send_start(1'b0, 32'd3, 32'd10, 32'd9, 32'd7, 32'd17, 32'd20, 1'b0, 1'b0);
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL timeout_err_clear got=%0b exp=0", err);
      end
      wait_done(400, cyc, to);
      e = sb.pop_front();
      checks++;
      if (to || {x3, y3, inf, err} !== {e.x3, e.y3, e.inf, e.err}) begin
         failures++;
         $display("FAIL timeout_recover timeout=%0b got x3=%0d y3=%0d err=%0b exp x3=%0d y3=%0d err=0",
                  to, x3, y3, err, e.x3, e.y3);
      end
   endtask
`endif

   initial begin : main
      repeat (2) @(posedge i_clk);
      #1;
      test_reset();
      @(negedge i_clk);
      i_rst = 1'b1;
      test_point_ops();
      test_infinity();
      test_ignore();
      test_back_to_back();
      test_reset_midop();
`ifdef ECC_POINT_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
